// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction memory and
// registers the returned word into the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic        fetch_fault,
    output logic [31:0] instr_count
);

    // Byte limit held in 33 bits so IMEM_WORDS*4 cannot overflow the compare.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic        valid_q,    valid_d;
    logic        misalign_q, misalign_d;
    logic        fault_q,    fault_d;
    logic [31:0] count_q,    count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        in_range;
    logic        redirect_in_range;

    assign pc_plus4          = pc_q + 32'd4;
    assign redirect_aligned  = {redirect_pc[31:2], 2'b00};
    assign in_range          = ({1'b0, pc_q} < PC_LIMIT);
    assign redirect_in_range = ({1'b0, redirect_aligned} < PC_LIMIT);

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        fault_d    = fault_q;
        count_d    = count_q;

        if (redirect_valid) begin
            pc_d       = redirect_aligned;
            instr_d    = 32'h0;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
            valid_d    = 1'b0;
            misalign_d = |redirect_pc[1:0];
            if (redirect_in_range) begin
                fault_d = 1'b0;
            end
        end else if (flush) begin
            instr_d  = 32'h0;
            id_pc_d  = 32'h0;
            id_pc4_d = 32'h0;
            valid_d  = 1'b0;
            if (!stall && in_range) begin
                pc_d = pc_plus4;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else if (in_range) begin
            instr_d  = imem_instr;
            id_pc_d  = pc_q;
            id_pc4_d = pc_plus4;
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
            count_d  = count_q + 32'd1;
        end else begin
            // Fetching beyond memory: park the PC and feed bubbles until redirected.
            instr_d  = 32'h0;
            id_pc_d  = 32'h0;
            id_pc4_d = 32'h0;
            valid_d  = 1'b0;
            fault_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = id_pc_q;
    assign if_id_pc4    = id_pc4_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = misalign_q;
    assign fetch_fault  = fault_q;
    assign instr_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 256-word instance and a 4-word instance,
// each backed by a memory model holding imem[i] = i+1.
module tb_fetch_stage;

    logic        clk;
    int          total;
    int          passed;

    logic        rst_n, stall, flush, rv;
    logic [31:0] rpc, addr, instr_in, id_instr, id_pc, id_pc4, count;
    logic        valid, mis, fault;

    logic        s_rst_n, s_stall, s_flush, s_rv;
    logic [31:0] s_rpc, s_addr, s_instr_in, s_id_instr, s_id_pc, s_id_pc4, s_count;
    logic        s_valid, s_mis, s_fault;

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [32:0] limit);
        if ({1'b0, a} < limit) return (a >> 2) + 32'd1;
        return 32'hDEAD_BEEF;
    endfunction

    assign instr_in   = mem_read(addr, 33'd1024);
    assign s_instr_in = mem_read(s_addr, 33'd16);

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(rv), .redirect_pc(rpc), .imem_addr(addr), .imem_instr(instr_in),
        .if_id_instr(id_instr), .if_id_pc(id_pc), .if_id_pc4(id_pc4), .if_id_valid(valid),
        .misalign_err(mis), .fetch_fault(fault), .instr_count(count)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(4)) u_small (
        .clk(clk), .rst_n(s_rst_n), .stall(s_stall), .flush(s_flush),
        .redirect_valid(s_rv), .redirect_pc(s_rpc), .imem_addr(s_addr), .imem_instr(s_instr_in),
        .if_id_instr(s_id_instr), .if_id_pc(s_id_pc), .if_id_pc4(s_id_pc4), .if_id_valid(s_valid),
        .misalign_err(s_mis), .fetch_fault(s_fault), .instr_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        total = 0; passed = 0;
        rst_n = 0; stall = 0; flush = 0; rv = 0; rpc = 0;
        s_rst_n = 0; s_stall = 0; s_flush = 0; s_rv = 0; s_rpc = 0;
        tick(); tick();
        check("rst_addr", addr, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_count", count, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_mis", 32'(mis), 32'h0);

        rst_n = 1;
        tick();
        check("e1_pc", id_pc, 32'h0);
        check("e1_instr", id_instr, 32'h1);
        check("e1_pc4", id_pc4, 32'h4);
        check("e1_valid", 32'(valid), 32'h1);
        check("e1_addr", addr, 32'h4);
        tick();
        check("e2_pc", id_pc, 32'h4);
        check("e2_instr", id_instr, 32'h2);
        tick();
        check("e3_pc", id_pc, 32'h8);
        check("e3_instr", id_instr, 32'h3);
        tick();
        check("e4_pc", id_pc, 32'hC);
        check("e4_count", count, 32'd4);
        check("e4_addr", addr, 32'h10);

        stall = 1;
        repeat (3) tick();
        check("stall_idpc", id_pc, 32'hC);
        check("stall_instr", id_instr, 32'h4);
        check("stall_addr", addr, 32'h10);
        check("stall_count", count, 32'd4);
        check("stall_valid", 32'(valid), 32'h1);
        stall = 0;
        tick();
        check("resume_pc", id_pc, 32'h10);
        check("resume_instr", id_instr, 32'h5);
        check("resume_count", count, 32'd5);

        stall = 1; rv = 1; rpc = 32'h40;
        tick();
        check("redir_addr", addr, 32'h40);
        check("redir_valid", 32'(valid), 32'h0);
        check("redir_instr", id_instr, 32'h0);
        check("redir_idpc", id_pc, 32'h0);
        check("redir_mis", 32'(mis), 32'h0);
        check("redir_count", count, 32'd5);
        stall = 0; rv = 0;
        tick();
        check("tgt_pc", id_pc, 32'h40);
        check("tgt_instr", id_instr, 32'd17);
        check("tgt_pc4", id_pc4, 32'h44);
        check("tgt_count", count, 32'd6);

        rv = 1; rpc = 32'h23;
        tick();
        check("mis_addr", addr, 32'h20);
        check("mis_pulse", 32'(mis), 32'h1);
        rv = 0;
        tick();
        check("mis_clear", 32'(mis), 32'h0);
        check("mis_idpc", id_pc, 32'h20);
        check("mis_instr", id_instr, 32'h9);
        check("mis_count", count, 32'd7);

        flush = 1; stall = 1;
        tick();
        check("fs_valid", 32'(valid), 32'h0);
        check("fs_instr", id_instr, 32'h0);
        check("fs_addr", addr, 32'h24);
        check("fs_count", count, 32'd7);
        stall = 0;
        tick();
        check("fl_valid", 32'(valid), 32'h0);
        check("fl_addr", addr, 32'h28);
        check("fl_count", count, 32'd7);
        flush = 0;
        tick();
        check("afl_pc", id_pc, 32'h28);
        check("afl_instr", id_instr, 32'd11);
        check("afl_count", count, 32'd8);

        rv = 1; rpc = 32'h3FC;
        tick();
        check("edge_addr", addr, 32'h3FC);
        rv = 0;
        tick();
        check("last_pc", id_pc, 32'h3FC);
        check("last_instr", id_instr, 32'd256);
        check("last_valid", 32'(valid), 32'h1);
        check("last_fault", 32'(fault), 32'h0);
        check("last_addr", addr, 32'h400);
        tick();
        check("oor_fault", 32'(fault), 32'h1);
        check("oor_valid", 32'(valid), 32'h0);
        check("oor_addr", addr, 32'h400);
        check("oor_count", count, 32'd9);
        rv = 1; rpc = 32'h0;
        tick();
        check("clr_fault", 32'(fault), 32'h0);
        check("clr_addr", addr, 32'h0);

        stall = 1; rv = 1; rpc = 32'h80; rst_n = 0;
        tick();
        check("mrst_addr", addr, 32'h0);
        check("mrst_count", count, 32'h0);
        check("mrst_valid", 32'(valid), 32'h0);
        check("mrst_mis", 32'(mis), 32'h0);
        stall = 0; rv = 0; rst_n = 1;

        s_rst_n = 1;
        repeat (4) tick();
        check("s_e4_pc", s_id_pc, 32'hC);
        check("s_e4_instr", s_id_instr, 32'h4);
        check("s_e4_addr", s_addr, 32'h10);
        check("s_e4_fault", 32'(s_fault), 32'h0);
        tick();
        check("s_fault", 32'(s_fault), 32'h1);
        check("s_valid", 32'(s_valid), 32'h0);
        check("s_addr", s_addr, 32'h10);
        tick();
        check("s_sticky", 32'(s_fault), 32'h1);
        check("s_hold_addr", s_addr, 32'h10);
        check("s_count", s_count, 32'd4);
        s_rv = 1; s_rpc = 32'h0;
        tick();
        check("s_clr_fault", 32'(s_fault), 32'h0);
        check("s_clr_addr", s_addr, 32'h0);
        s_rv = 0;
        tick();
        check("s_refetch_valid", 32'(s_valid), 32'h1);
        check("s_refetch_instr", s_id_instr, 32'h1);
        check("s_refetch_count", s_count, 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
